// File: rtl/acq_sequencer.sv
// -----------------------------------------------------------------------------
// acq_sequencer
//   Runs one acquisition into a circular sample buffer: pre-trigger fill, wait
//   for a trigger, post-trigger fill, then holds the buffer for readers. It can
//   re-arm on its own (continuous mode) or stop after one capture. It drives the
//   sample RAM write strobe/address and reports where the oldest sample of the
//   last completed capture lives.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   sample_valid_i        one ADC sample available this cycle
//   arm_i                 start an acquisition (IDLE only)
//   continuous_i          latched at arm; 1 = re-arm after read_done_i
//   pretrig_len_i         requested pre-trigger length, clamped to DEPTH-1
//   trigger_i             qualified trigger event
//   force_trig_i          manual trigger, handled like trigger_i
//   abort_i               return to IDLE, highest priority
//   read_done_i           readers are finished with the buffer (DONE only)
//   wr_en_o, wr_addr_o    sample RAM write port (wr_en_o is combinational)
//   sample_start_addr_o   address of the oldest sample of the last capture
//   capture_valid_o       buffer holds a complete capture
//   triggered_o           one-cycle pulse after a trigger was accepted
//   state_o               IDLE=0 PRETRIG=1 WAIT_TRIG=2 POSTTRIG=3 DONE=4
// -----------------------------------------------------------------------------
module acq_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid_i,
  input  logic              arm_i,
  input  logic              continuous_i,
  input  logic [ADDR_W-1:0] pretrig_len_i,
  input  logic              trigger_i,
  input  logic              force_trig_i,
  input  logic              abort_i,
  input  logic              read_done_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W-1:0] sample_start_addr_o,
  output logic              capture_valid_o,
  output logic              triggered_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    POSTTRIG  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  // One extra bit so DEPTH itself is representable when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_next;
  logic [ADDR_W-1:0] p_eff, p_eff_in;
  logic [ADDR_W-1:0] pre_cnt, post_cnt;
  logic              cont;
  logic              accept, load_cfg, enter_done;
  logic [ADDR_W:0]   start_sum, start_wrap;
  logic [ADDR_W-1:0] start_next, addr_next;

  // Pre-trigger length can never use the whole buffer: the trigger sample
  // always needs one slot.
  assign p_eff_in = (pretrig_len_i > LAST) ? LAST : pretrig_len_i;

  // Oldest sample = trigger address minus P_eff, modulo DEPTH.
  assign start_sum  = {1'b0, wr_addr_o} + DEPTH_X - {1'b0, p_eff};
  assign start_wrap = start_sum - DEPTH_X;
  assign start_next = (start_sum >= DEPTH_X) ? start_wrap[ADDR_W-1:0]
                                             : start_sum[ADDR_W-1:0];

  assign addr_next  = (wr_addr_o == LAST) ? '0 : wr_addr_o + ONE;
  assign state_o    = state;
  assign enter_done = (state_next == DONE) && (state != DONE);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    wr_en_o    = 1'b0;
    accept     = 1'b0;
    load_cfg   = 1'b0;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm_i) begin
            load_cfg   = 1'b1;
            state_next = (p_eff_in != '0) ? PRETRIG : WAIT_TRIG;
          end
        end
        PRETRIG: begin
          wr_en_o = sample_valid_i;
          if (sample_valid_i && (pre_cnt + ONE == p_eff)) state_next = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          wr_en_o = sample_valid_i;
          // A trigger only counts on a cycle that also carries a sample.
          if (sample_valid_i && (trigger_i || force_trig_i)) begin
            accept     = 1'b1;
            state_next = (p_eff == LAST) ? DONE : POSTTRIG;
          end
        end
        POSTTRIG: begin
          wr_en_o = sample_valid_i;
          if (sample_valid_i && (post_cnt == ONE)) state_next = DONE;
        end
        DONE: begin
          if (read_done_i) begin
            if (cont) begin
              load_cfg   = 1'b1;
              state_next = (p_eff_in != '0) ? PRETRIG : WAIT_TRIG;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      wr_addr_o           <= '0;
      sample_start_addr_o <= '0;
      capture_valid_o     <= 1'b0;
      triggered_o         <= 1'b0;
      p_eff               <= '0;
      pre_cnt             <= '0;
      post_cnt            <= '0;
      cont                <= 1'b0;
    end else begin
      state       <= state_next;
      triggered_o <= accept;

      // Write pointer free-runs across acquisitions; re-arming never rewinds it.
      if (wr_en_o) wr_addr_o <= addr_next;

      if (load_cfg) begin
        p_eff   <= p_eff_in;
        pre_cnt <= '0;
        if (state == IDLE) cont <= continuous_i;
      end else if (state == PRETRIG && wr_en_o) begin
        pre_cnt <= pre_cnt + ONE;
      end

      if (accept) begin
        sample_start_addr_o <= start_next;
        post_cnt            <= LAST - p_eff;
      end else if (state == POSTTRIG && wr_en_o) begin
        post_cnt <= post_cnt - ONE;
      end

      // Completing a capture outranks the write that completes it; any other
      // write means a new acquisition is overwriting the old one.
      if (abort_i)                          capture_valid_o <= 1'b0;
      else if (enter_done)                  capture_valid_o <= 1'b1;
      else if (wr_en_o)                     capture_valid_o <= 1'b0;
      else if (state == DONE && read_done_i) capture_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_sequencer
//   Drives acq_sequencer (DEPTH=16) with directed scenarios and random traffic,
//   comparing every output each cycle against a sample-counting model of the
//   acquisition, plus literal expectations for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_acq_sequencer;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid_i = 1'b0, arm_i = 1'b0, continuous_i = 1'b0;
  logic [ADDR_W-1:0] pretrig_len_i = '0;
  logic              trigger_i = 1'b0, force_trig_i = 1'b0, abort_i = 1'b0, read_done_i = 1'b0;
  logic              wr_en_o, capture_valid_o, triggered_o;
  logic [ADDR_W-1:0] wr_addr_o, sample_start_addr_o;
  logic [2:0]        state_o;

  always #5 clk = ~clk;

  acq_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid_i(sample_valid_i), .arm_i(arm_i),
    .continuous_i(continuous_i), .pretrig_len_i(pretrig_len_i), .trigger_i(trigger_i),
    .force_trig_i(force_trig_i), .abort_i(abort_i), .read_done_i(read_done_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .sample_start_addr_o(sample_start_addr_o),
    .capture_valid_o(capture_valid_o), .triggered_o(triggered_o), .state_o(state_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The acquisition is described by how many samples it has taken, not by
  // states: before the trigger it is "pre-filling" until P samples exist, then
  // "waiting"; after the trigger it counts down the samples still owed.
  bit m_idle, m_active, m_done, m_cont, m_trig_seen, m_valid, m_pulse;
  int m_p, m_pre_writes, m_post_left, m_addr, m_start;

  function automatic int clamp_p(input int plen);
    return (plen > DEPTH - 1) ? DEPTH - 1 : plen;
  endfunction

  function automatic int model_state();
    if (m_done)                                      return 4;
    if (!m_active)                                   return 0;
    if (m_trig_seen)                                 return 3;
    if (m_pre_writes < m_p)                          return 1;
    return 2;
  endfunction

  function automatic bit model_wr_en();
    return sample_valid_i && m_active && !abort_i;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_active = 0; m_done = 0; m_cont = 0; m_trig_seen = 0;
    m_valid = 0; m_pulse = 0; m_p = 0; m_pre_writes = 0; m_post_left = 0;
    m_addr = 0; m_start = 0;
  endtask

  task automatic model_start();
    m_p = clamp_p(int'(pretrig_len_i));
    m_pre_writes = 0; m_trig_seen = 0; m_active = 1; m_idle = 0; m_done = 0;
  endtask

  task automatic model_finish();
    m_active = 0; m_done = 1; m_valid = 1;
  endtask

  task automatic model_step();
    bit we;
    int old_addr;
    we = model_wr_en();
    old_addr = m_addr;
    m_pulse = 0;
    if (abort_i) begin
      m_idle = 1; m_active = 0; m_done = 0; m_valid = 0;
      return;
    end
    if (we) begin
      m_addr = (m_addr + 1) % DEPTH;
      m_valid = 0;
    end
    if (m_idle) begin
      if (arm_i) begin
        m_cont = continuous_i;
        model_start();
      end
    end else if (m_active && !m_trig_seen && m_pre_writes < m_p) begin
      if (sample_valid_i) m_pre_writes++;
    end else if (m_active && !m_trig_seen) begin
      if (sample_valid_i && (trigger_i || force_trig_i)) begin
        m_trig_seen = 1;
        m_pulse = 1;
        m_start = (old_addr + DEPTH - m_p) % DEPTH;
        m_post_left = DEPTH - 1 - m_p;
        if (m_post_left == 0) model_finish();
      end
    end else if (m_active) begin
      if (sample_valid_i) begin
        m_post_left--;
        if (m_post_left == 0) model_finish();
      end
    end else if (m_done && read_done_i) begin
      m_valid = 0;
      if (m_cont) model_start();
      else begin m_done = 0; m_idle = 1; end
    end
  endtask

  // ---------------- per-cycle driver + compare ----------------
  bit obs_wr_en;
  int obs_wr_addr;

  task automatic compare_outputs();
    check("wr_en",         wr_en_o,             model_wr_en());
    check("wr_addr",       wr_addr_o,           m_addr);
    check("start_addr",    sample_start_addr_o, m_start);
    check("capture_valid", capture_valid_o,     m_valid);
    check("triggered",     triggered_o,         m_pulse);
    check("state",         state_o,             model_state());
  endtask

  task automatic cycle(input bit v, input bit arm, input bit cont, input int plen,
                       input bit trig, input bit ftrig, input bit abrt, input bit rd);
    @(negedge clk);
    sample_valid_i = v; arm_i = arm; continuous_i = cont;
    pretrig_len_i = ADDR_W'(plen > 15 ? 15 : plen);
    trigger_i = trig; force_trig_i = ftrig; abort_i = abrt; read_done_i = rd;
    #1;
    compare_outputs();
    obs_wr_en = wr_en_o;
    if (wr_en_o) obs_wr_addr = int'(wr_addr_o);
    @(posedge clk);
    model_step();
    #1;
  endtask

  // pretrig_len_i is only 4 bits here; the clamp is exercised through P=15.
  task automatic samples(input int n, input bit trig);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, trig, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    sample_valid_i = 0; arm_i = 0; continuous_i = 0; pretrig_len_i = '0;
    trigger_i = 0; force_trig_i = 0; abort_i = 0; read_done_i = 0;
    model_reset();
    #2;
    check("rst_state", state_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_start", sample_start_addr_o, 0);
    check("rst_valid", capture_valid_o, 0);
    check("rst_trig", triggered_o, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();

    // 1) P=4 single shot, trigger on the sample at address 9.
    do_reset();
    cycle(0, 1, 0, 4, 0, 0, 0, 0);
    check("t1_state_pre", state_o, 1);
    samples(9, 0);
    samples(1, 1);
    check("t1_start", sample_start_addr_o, 5);
    check("t1_pulse", triggered_o, 1);
    samples(11, 0);
    check("t1_done", state_o, 4);
    check("t1_valid", capture_valid_o, 1);
    check("t1_last_addr", obs_wr_addr, 4);
    samples(3, 1);
    check("t1_no_write", obs_wr_en, 0);

    // 2) Trigger held high through PRETRIG: accepted on first WAIT_TRIG sample.
    do_reset();
    cycle(0, 1, 0, 4, 1, 0, 0, 0);
    samples(4, 1);
    check("t2_wait", state_o, 2);
    samples(1, 1);
    check("t2_post", state_o, 3);
    check("t2_start", sample_start_addr_o, 0);

    // 3) P_eff = DEPTH-1, trigger at address 15: N=0, DONE at once.
    do_reset();
    cycle(0, 1, 0, 20, 0, 0, 0, 0);
    samples(15, 0);
    samples(1, 1);
    check("t3_done", state_o, 4);
    check("t3_start", sample_start_addr_o, 0);
    check("t3_valid", capture_valid_o, 1);

    // 4) Trigger without a sample is ignored; next valid sample at addr 2 wraps.
    do_reset();
    cycle(0, 1, 0, 4, 0, 0, 0, 0);
    samples(18, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);
    check("t4_no_accept", state_o, 2);
    cycle(1, 0, 0, 0, 0, 1, 0, 0);
    check("t4_start", sample_start_addr_o, 14);

    // 5) Abort in POSTTRIG with a sample present.
    samples(2, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    check("t5_abort_wr", obs_wr_en, 0);
    check("t5_idle", state_o, 0);
    check("t5_valid", capture_valid_o, 0);
    check("t5_start", sample_start_addr_o, 14);

    // 6) Continuous re-arm; then abort and read_done together.
    do_reset();
    cycle(0, 1, 1, 2, 0, 0, 0, 0);
    samples(2, 0);
    samples(1, 1);
    samples(13, 0);
    check("t6_done", state_o, 4);
    cycle(0, 0, 0, 2, 0, 0, 0, 1);
    check("t6_rearm", state_o, 1);
    check("t6_valid", capture_valid_o, 0);
    samples(2, 0);
    samples(1, 1);
    samples(13, 0);
    check("t6_done2", state_o, 4);
    cycle(0, 0, 0, 2, 0, 0, 1, 1);
    check("t6_abort_idle", state_o, 0);

    // 7) Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0, $urandom_range(0, 149) == 0,
            $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
